mmio_port_responder: RTL and testbench
======================================

// Module: mmio_port_responder
// PURPOSE
//  Memory-mapped I/O responder answering processor load/store requests for the board ports.
//  Owns the PortOut register and a synchronized, change-flagged copy of PortIn.
//  Sits beside DataMemory on the data side and replaces the constant PortOut tie-off.
//  Uses a req/ack handshake with programmable wait states to model a slow peripheral bus.
// PARAMETERS
//  BASE_ADDR   32'h1001_0040  word-aligned base address of the 16-byte register window
//  WAIT_STATES 0              extra cycles (0..15) between request acceptance and ack
//  OUT_RESET   32'h0000_0000  PortOut value loaded on reset
// PORTS
//  clk        in   1   clock; all logic on the rising edge
//  reset      in   1   reset is synchronous and active-low
//  req        in   1   processor access request, held until ack
//  we         in   1   1=store, 0=load; stable while req=1
//  addr       in   32  byte address; stable while req=1
//  wdata      in   32  store data; stable while req=1
//  ack        out  1   one-cycle completion pulse
//  rdata      out  32  load data, valid only while ack=1, else 0
//  hit        out  1   comb: addr[31:4]==BASE_ADDR[31:4]
//  PortIn     in   8   asynchronous board switches
//  PortOut    out  32  registered output port
//  irq        out  1   change interrupt (only with PORTIN_IRQ_EN)
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, ack=0, rdata=0, PortOut=OUT_RESET, CHG=0,
//   sync flops=0, wait counter=0, irq=0. Reset mid-transaction aborts it; no ack is issued.
//  Register map (offset addr[3:2]); addr[1:0] is ignored:
//   0 PORT_OUT  RW  32-bit
//   1 PORT_IN   RO  {24'b0, sync_in}
//   2 STATUS    RW  bit0 CHG, set by hardware, write-1-to-clear; bit1 IRQ_EN_REG
//   3 reserved  reads 0, writes ignored
//  FSM:
//   IDLE -> WAIT when req&hit and WAIT_STATES>0; loads cnt=WAIT_STATES-1.
//   IDLE -> RESP when req&hit and WAIT_STATES==0.
//   WAIT: cnt decrements each cycle; at cnt==0 -> RESP.
//   RESP: ack=1 for exactly one cycle, then -> IDLE.
//   req&!hit is ignored; the responder stays IDLE.
//  Latency: req accepted at cycle 0 gives ack at cycle WAIT_STATES+1.
//  Requester drops req, or presents a new request, in the cycle after ack. IDLE may accept a
//   new request immediately, giving back-to-back throughput of one access per WAIT_STATES+2 cycles.
//  Address, we and wdata are latched on acceptance; later changes on the inputs are ignored.
//  Stores commit on the edge entering RESP, so PortOut shows the new value during the ack cycle.
//  Loads: rdata is registered on the edge entering RESP and returns to 0 after ack.
//  PortIn path: two-flop synchronizer to sync_in, plus a prev_in flop.
//   CHG is set when sync_in!=prev_in.
//  CHG set and W1C in the same cycle: set wins, CHG stays 1.
//  Load and store to PORT_IN both complete with ack. A store to PORT_IN has no effect.
// CONFIGURATION
//  PORTIN_IRQ_EN defined:
//   irq = registered (CHG & IRQ_EN_REG); asserts the cycle after CHG sets; clears with CHG.
//   STATUS bit1 is writable.
//  PORTIN_IRQ_EN undefined:
//   irq tied to 0; STATUS bit1 reads 0 and writes to it are ignored; no extra flops.
// TESTING
//  T1 Reset:
//   hold reset=0 2 cycles -> PortOut=0, ack=0, rdata=0; STATUS load -> 0.
//  T2 Store/load, WAIT_STATES=0:
//   sw 32'hCAFE_0001 to 0x1001_0040 -> ack at cycle 1, PortOut=CAFE_0001 in the ack cycle;
//   lw from the same address -> rdata=CAFE_0001.
//  T3 Wait states, WAIT_STATES=3:
//   lw from 0x1001_0044 with PortIn=8'hA5 held >=3 cycles -> ack exactly at cycle 4, rdata=32'h0000_00A5.
//  T4 Change flag:
//   PortIn 00->3C -> CHG=1 within 3 cycles.
//   Pulse the change and W1C in the same cycle -> CHG stays 1.
//   Plain W1C of 1 -> STATUS reads 0.
//  T5 Miss, back-to-back, reset abort:
//   req to 0x1001_0050 -> no ack for 20 cycles.
//   Two stores issued back-to-back -> both acked, PortOut holds the second value.
//   reset=0 during WAIT -> no ack, PortOut=OUT_RESET.
//  T6 IRQ (PORTIN_IRQ_EN):
//   STATUS=2, toggle PortIn -> irq=1; W1C CHG -> irq=0 the next cycle.
//   Without PORTIN_IRQ_EN -> irq stays 0.

Source files
------------

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: MMIO responder for PortOut, synchronized PortIn and STATUS with wait states; PORTIN_IRQ_EN adds irq and STATUS bit1
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0040,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] l_off, op_off;
  logic l_we, op_we;
  logic [31:0] l_wdata, op_wdata, rd_val;
  logic [7:0] s1, sync_in, prev_in;
  logic chg, irq_en, accept, commit, w1c;
  logic unused_ok;
  assign unused_ok = &{1'b0, addr[1:0]};
  assign hit = addr[31:4] == BASE_ADDR[31:4];
  assign accept = state == IDLE && req && hit;
  assign ack = state == RESP;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = (WS == 4'd0) ? RESP : WAIT;
        cnt_n = WS - 4'd1;
      end
      WAIT: begin
        state_n = (cnt == 4'd0) ? RESP : WAIT;
        cnt_n = (cnt == 4'd0) ? cnt : cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign commit = state_n == RESP && state != RESP;
  assign op_off = state == IDLE ? addr[3:2] : l_off;
  assign op_we = state == IDLE ? we : l_we;
  assign op_wdata = state == IDLE ? wdata : l_wdata;
  assign w1c = commit && op_we && op_off == 2'd2 && op_wdata[0];
  assign rd_val = op_off == 2'd0 ? PortOut :
                  op_off == 2'd1 ? {24'b0, sync_in} :
                  op_off == 2'd2 ? {30'b0, irq_en, chg} : 32'b0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      PortOut <= OUT_RESET;
      chg <= 1'b0;
      s1 <= '0;
      sync_in <= '0;
      prev_in <= '0;
      l_off <= '0;
      l_we <= 1'b0;
      l_wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        l_off <= addr[3:2];
        l_we <= we;
        l_wdata <= wdata;
      end
      rdata <= (commit && !op_we) ? rd_val : 32'b0;
      if (commit && op_we && op_off == 2'd0) PortOut <= op_wdata;
      s1 <= PortIn;
      sync_in <= s1;
      prev_in <= sync_in;
      chg <= (sync_in != prev_in) || (chg && !w1c);
    end
  end
`ifdef PORTIN_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (commit && op_we && op_off == 2'd2) irq_en <= op_wdata[1];
      irq <= chg && irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: randomized bench with a transaction-level register model and per-cycle output compare
module tb_mmio_port_responder;
  localparam logic [31:0] BASE = 32'h1001_0040;
  localparam int WS = 3;
  localparam logic [31:0] ORST = 32'h0000_0000;
  logic clk = 0, reset = 0, req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [7:0] PortIn = 0;
  logic ack, hit, irq;
  logic [31:0] rdata, PortOut;
  int n_cmp = 0, n_err = 0, cyc = 0, exp_ack_cyc = -1;
  bit rst_q = 0, chk_en = 0;
  logic [31:0] m_out = ORST, m_rd = 0, p_wdata = 0;
  bit m_chg = 0, m_en = 0, p_we = 0;
  logic [1:0] p_off = 0;
  mmio_port_responder #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .OUT_RESET(ORST)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .hit(hit), .PortIn(PortIn), .PortOut(PortOut), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_q <= !reset;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    m_rd = 0;
    if (rst_q) begin
      m_out = ORST;
      m_chg = 0;
      m_en = 0;
      exp_ack_cyc = -1;
    end else if (cyc == exp_ack_cyc) begin
      if (!p_we)
        m_rd = p_off == 0 ? m_out : p_off == 1 ? {24'b0, PortIn} : p_off == 2 ? {30'b0, m_en, m_chg} : 32'b0;
      else if (p_off == 0)
        m_out = p_wdata;
      else if (p_off == 2) begin
        if (p_wdata[0]) m_chg = 0;
`ifdef PORTIN_IRQ_EN
        m_en = p_wdata[1];
`endif
      end
    end
    check("ack", {31'b0, ack}, {31'b0, cyc == exp_ack_cyc});
    check("rdata", rdata, m_rd);
    check("PortOut", PortOut, m_out);
    check("hit", {31'b0, hit}, {31'b0, addr >= BASE && addr < BASE + 32'd16});
`ifndef PORTIN_IRQ_EN
    check("irq", {31'b0, irq}, 32'd0);
`endif
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input int tog,
                     output int lat, output logic [31:0] rd, output logic [31:0] po);
    req = 1; we = w; addr = a; wdata = d;
    p_we = w; p_off = a[3:2]; p_wdata = d;
    exp_ack_cyc = cyc + WS + 1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == tog) PortIn = PortIn ^ 8'hFF;
      we = 1'($urandom); addr = $urandom; wdata = $urandom;
    end while (!ack && lat < 40);
    rd = rdata;
    po = PortOut;
    check("ack_latency", lat, WS + 1);
    tick();
    req = 0; we = 0; addr = 0;
  endtask
  task automatic miss(input int n);
    int acks;
    acks = 0;
    req = 1; we = 1'($urandom); wdata = $urandom;
    addr = (BASE ^ (32'h10 << $urandom_range(0, 27))) | 32'($urandom_range(0, 15));
    repeat (n) begin
      tick();
      if (ack) acks++;
    end
    check("miss_no_ack", acks, 0);
    req = 0; addr = 0;
  endtask
  task automatic set_port(input logic [7:0] v);
    bit changed;
    changed = v != PortIn;
    PortIn = v;
    repeat (4) tick();
    if (changed) m_chg = 1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, acks;
    logic [31:0] rd, po;
    #1;
    repeat (2) tick();
    check("t1_portout", PortOut, 32'h0);
    check("t1_ack", {31'b0, ack}, 32'd0);
    check("t1_rdata", rdata, 32'h0);
    reset = 1; chk_en = 1;
    tick();
    txn(0, BASE + 8, 0, -1, lat, rd, po);
    check("t1_status", rd, 32'h0);
    txn(1, BASE, 32'hCAFE_0001, -1, lat, rd, po);
    check("t2_store_portout", po, 32'hCAFE_0001);
    txn(0, BASE, 0, -1, lat, rd, po);
    check("t2_load", rd, 32'hCAFE_0001);
    set_port(8'hA5);
    txn(0, BASE + 4, 0, -1, lat, rd, po);
    check("t3_latency", lat, 4);
    check("t3_rdata", rd, 32'h0000_00A5);
    set_port(8'h00);
    txn(1, BASE + 8, 1, -1, lat, rd, po);
    PortIn = 8'h3C;
    repeat (3) tick();
    m_chg = 1;
    txn(0, BASE + 8, 0, -1, lat, rd, po);
    check("t4_chg_set", rd, 32'h1);
    txn(1, BASE + 8, 1, -1, lat, rd, po);
    txn(1, BASE + 8, 1, WS - 2, lat, rd, po);
    m_chg = 1;
    repeat (3) tick();
    txn(0, BASE + 8, 0, -1, lat, rd, po);
    check("t4_set_wins", rd, 32'h1);
    txn(1, BASE + 8, 1, -1, lat, rd, po);
    txn(0, BASE + 10, 0, -1, lat, rd, po);
    check("t4_w1c", rd, 32'h0);
    miss(20);
    txn(1, BASE + 1, 32'h1111_2222, -1, lat, rd, po);
    txn(1, BASE + 3, 32'h3333_4444, -1, lat, rd, po);
    check("t5_b2b_portout", PortOut, 32'h3333_4444);
    txn(0, BASE + 12, 0, -1, lat, rd, po);
    check("t5_reserved", rd, 32'h0);
    req = 1; we = 1; addr = BASE; wdata = 32'h5555_AAAA;
    p_we = 1; p_off = 0; p_wdata = wdata;
    exp_ack_cyc = cyc + WS + 1;
    tick();
    reset = 0;
    tick();
    reset = 1; req = 0;
    acks = 0;
    repeat (8) begin
      tick();
      if (ack) acks++;
    end
    check("t5_abort_no_ack", acks, 0);
    check("t5_abort_portout", PortOut, ORST);
    if (PortIn != 0) m_chg = 1;
`ifdef PORTIN_IRQ_EN
    txn(1, BASE + 8, 1, -1, lat, rd, po);
    txn(1, BASE + 8, 2, -1, lat, rd, po);
    set_port(PortIn ^ 8'h0F);
    check("t6_irq_on", {31'b0, irq}, 32'd1);
    txn(1, BASE + 8, 3, -1, lat, rd, po);
    check("t6_irq_off", {31'b0, irq}, 32'd0);
    txn(1, BASE + 8, 0, -1, lat, rd, po);
`else
    set_port(PortIn ^ 8'h0F);
    check("t6_irq_off", {31'b0, irq}, 32'd0);
`endif
    repeat (200) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) set_port(8'($urandom));
      else if (k == 1) miss($urandom_range(2, 6));
      else begin
        repeat ($urandom_range(0, 1)) tick();
        txn(1'($urandom), BASE + 32'($urandom_range(0, 15)), $urandom, -1, lat, rd, po);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
